imem_fetch_unit: RTL and testbench

IMEM_FETCH_UNIT -- requirements
Module: imem_fetch_unit

---
 rtl/imem_fetch_unit.sv | 127 ++++++++++++
 tb/tb_imem_fetch_unit.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_fetch_unit.sv
// Instruction memory with prefetch queue: loads words, fetches sequentially from a redirect PC.
// Optional IMEM_PARITY_EN adds a stored even-parity bit per word, checked on read.
module imem_fetch_unit #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned ADDR_W     = 6,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              halt,
  output logic              instr_valid,
  output logic [DATA_W-1:0] instr_data,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              instr_ready,
  output logic              instr_parity_err,
  output logic              busy
);

  localparam int unsigned MEM_DEPTH = 2**ADDR_W;
  localparam int unsigned PTR_W     = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W     = $clog2(FIFO_DEPTH + 1);
`ifdef IMEM_PARITY_EN
  localparam int unsigned MEM_W     = DATA_W + 1;
`else
  localparam int unsigned MEM_W     = DATA_W;
`endif

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]        r_state;
  logic [ADDR_W-1:0] r_fetch_pc;
  logic              r_inflight;
  logic [ADDR_W-1:0] r_inflight_pc;
  logic [MEM_W-1:0]  r_mem [MEM_DEPTH];
  logic [MEM_W-1:0]  r_rd_word;

  logic [DATA_W-1:0] r_q_data [FIFO_DEPTH];
  logic [ADDR_W-1:0] r_q_pc   [FIFO_DEPTH];
  logic              r_q_perr [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;

  logic              w_flush;
  logic              w_pop;
  logic              w_push;
  logic              w_issue;
  logic [ADDR_W-1:0] w_issue_addr;
  logic [CNT_W-1:0]  w_occ;
  logic [MEM_W-1:0]  w_load_word;
  logic              w_rd_perr;

`ifdef IMEM_PARITY_EN
  assign w_load_word = {^load_data, load_data};
  assign w_rd_perr   = ^r_rd_word;
`else
  assign w_load_word = load_data;
  assign w_rd_perr   = 1'b0;
`endif

  assign w_flush      = halt | redirect_valid;
  assign w_pop        = instr_valid & instr_ready;
  assign w_push       = r_inflight & ~w_flush;
  assign w_occ        = r_count + CNT_W'(r_inflight);
  // A redirect issues its first read in the same cycle, so the queue flush makes room regardless of w_occ.
  assign w_issue      = ~rst & ~load_en & ~halt &
                        (redirect_valid | ((r_state == S_RUN) & (w_occ < CNT_W'(FIFO_DEPTH))));
  assign w_issue_addr = redirect_valid ? redirect_pc : r_fetch_pc;

  always_ff @(posedge clk) begin
    if (load_en && !rst) r_mem[load_addr] <= w_load_word;
    if (w_issue)         r_rd_word <= r_mem[w_issue_addr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_fetch_pc    <= '0;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
    end else begin
      if (halt)                r_state <= S_IDLE;
      else if (redirect_valid) r_state <= S_RUN;

      if (w_issue)                      r_fetch_pc <= w_issue_addr + 1'b1;
      else if (redirect_valid && !halt) r_fetch_pc <= redirect_pc;

      r_inflight <= w_issue;
      if (w_issue) r_inflight_pc <= w_issue_addr;

      if (w_flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
        else if (!w_push && w_pop) r_count <= r_count - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_data[r_wr_ptr] <= r_rd_word[DATA_W-1:0];
      r_q_pc[r_wr_ptr]   <= r_inflight_pc;
      r_q_perr[r_wr_ptr] <= w_rd_perr;
    end
  end

  assign instr_valid      = (r_count != '0);
  assign instr_data       = instr_valid ? r_q_data[r_rd_ptr] : '0;
  assign instr_pc         = instr_valid ? r_q_pc[r_rd_ptr]   : '0;
  assign instr_parity_err = instr_valid & r_q_perr[r_rd_ptr];
  assign busy             = (r_state == S_RUN);

endmodule

// File: tb/tb_imem_fetch_unit.sv
// Scoreboard bench for imem_fetch_unit: stimulus queues expected head entries, a monitor pops on each handshake.
module tb_imem_fetch_unit;
  localparam int DW = 16;
  localparam int AW = 6;

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [DW-1:0] data;
    logic          perr;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          load_en = 1'b0;
  logic [AW-1:0] load_addr = '0;
  logic [DW-1:0] load_data = '0;
  logic          redirect_valid = 1'b0;
  logic [AW-1:0] redirect_pc = '0;
  logic          halt = 1'b0;
  logic          instr_ready = 1'b0;
  logic          instr_valid;
  logic [DW-1:0] instr_data;
  logic [AW-1:0] instr_pc;
  logic          instr_parity_err;
  logic          busy;

  int            n_checks = 0;
  int            n_errors = 0;
  exp_t          exp_q[$];
  logic [DW-1:0] mem_m [64];
  logic          bad_en = 1'b0;
  logic [AW-1:0] bad_pc = 6'd5;
  int            cyc;

  imem_fetch_unit #(.DATA_W(DW), .ADDR_W(AW), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt(halt),
    .instr_valid(instr_valid), .instr_data(instr_data), .instr_pc(instr_pc),
    .instr_ready(instr_ready), .instr_parity_err(instr_parity_err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && instr_valid && instr_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_entry: actual pc=%0d data=0x%0h required none", instr_pc, instr_data);
      end else begin : pop_blk
        exp_t e;
        e = exp_q.pop_front();
        chk("head_pc", 32'(instr_pc), 32'(e.pc));
        chk("head_data", 32'(instr_data), 32'(e.data));
        chk("head_perr", 32'(instr_parity_err), 32'(e.perr));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [AW-1:0] a, input logic [DW-1:0] d);
    load_en = 1'b1; load_addr = a; load_data = d;
    tick();
    load_en = 1'b0;
    mem_m[a] = d;
  endtask

  task automatic expect_run(input logic [AW-1:0] start, input int n);
    for (int i = 0; i < n; i++) begin
      exp_t e;
      e.pc   = AW'(int'(start) + i);
      e.data = mem_m[e.pc];
      e.perr = bad_en && (e.pc == bad_pc);
      exp_q.push_back(e);
    end
  endtask

  task automatic redirect_to(input logic [AW-1:0] pc);
    redirect_valid = 1'b1; redirect_pc = pc;
    tick();
    redirect_valid = 1'b0;
    chk("valid_low_after_redirect", 32'(instr_valid), 32'd0);
    chk("busy_after_redirect", 32'(busy), 32'd1);
  endtask

  task automatic drain(output int c);
    c = 0;
    while (exp_q.size() != 0 && c < 200) begin
      tick();
      c++;
    end
    if (c >= 200) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain_timeout: actual %0d entries left required 0", exp_q.size());
    end
  endtask

  task automatic finish_stream();
    instr_ready = 1'b0; halt = 1'b1;
    tick();
    halt = 1'b0;
    chk("valid_after_halt", 32'(instr_valid), 32'd0);
    chk("busy_after_halt", 32'(busy), 32'd0);
    chk("leftover_expected", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tick(); tick();
    rst = 1'b0;
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_data", 32'(instr_data), 32'd0);
    chk("rst_pc", 32'(instr_pc), 32'd0);
    chk("rst_perr", 32'(instr_parity_err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);

    for (int a = 0; a < 64; a++) load_word(AW'(a), DW'(16'h1000 + a));
    repeat (3) tick();
    chk("idle_no_fetch", 32'(instr_valid), 32'd0);

    // Sequential stream 0..15, one word per cycle after 2-cycle latency
    instr_ready = 1'b1;
    expect_run(6'd0, 16);
    redirect_to(6'd0);
    drain(cyc);
    chk("stream0_cycles", 32'(cyc), 32'd17);
    finish_stream();

    // Address wrap 62,63,0
    load_word(6'd62, 16'hAAAA);
    load_word(6'd63, 16'hBBBB);
    load_word(6'd0,  16'hCCCC);
    instr_ready = 1'b1;
    expect_run(6'd62, 3);
    redirect_to(6'd62);
    drain(cyc);
    chk("wrap_cycles", 32'(cyc), 32'd4);
    finish_stream();

    // Back-pressure: queue fills, head holds, then drains in order
    instr_ready = 1'b0;
    redirect_to(6'd0);
    repeat (10) tick();
    chk("hold_valid", 32'(instr_valid), 32'd1);
    chk("hold_pc", 32'(instr_pc), 32'd0);
    chk("hold_data", 32'(instr_data), 32'(mem_m[0]));
    expect_run(6'd0, 8);
    instr_ready = 1'b1;
    drain(cyc);
    chk("backpressure_cycles", 32'(cyc), 32'd8);
    finish_stream();

    // Mid-stream redirect discards queued entries
    instr_ready = 1'b0;
    redirect_to(6'd0);
    repeat (3) tick();
    chk("pre_redirect_valid", 32'(instr_valid), 32'd1);
    redirect_to(6'd40);
    expect_run(6'd40, 5);
    instr_ready = 1'b1;
    drain(cyc);
    chk("redirect40_cycles", 32'(cyc), 32'd6);
    finish_stream();

    // Loads during RUN cost two issue slots, sequence stays continuous
    instr_ready = 1'b1;
    expect_run(6'd20, 10);
    redirect_to(6'd20);
    load_en = 1'b1; load_addr = 6'd50; load_data = 16'h5050;
    tick();
    load_addr = 6'd51; load_data = 16'h5151;
    tick();
    load_en = 1'b0;
    mem_m[50] = 16'h5050;
    mem_m[51] = 16'h5151;
    drain(cyc);
    chk("load_bubble_cycles", 32'(cyc + 2), 32'd13);
    finish_stream();
    instr_ready = 1'b1;
    expect_run(6'd50, 2);
    redirect_to(6'd50);
    drain(cyc);
    chk("loaded_cycles", 32'(cyc), 32'd3);
    finish_stream();

    // Reset mid-fetch; the load in the reset cycle is dropped
    instr_ready = 1'b0;
    redirect_to(6'd10);
    repeat (3) tick();
    rst = 1'b1; load_en = 1'b1; load_addr = 6'd10; load_data = 16'hDEAD;
    tick();
    rst = 1'b0; load_en = 1'b0;
    chk("midrst_valid", 32'(instr_valid), 32'd0);
    chk("midrst_data", 32'(instr_data), 32'd0);
    chk("midrst_pc", 32'(instr_pc), 32'd0);
    chk("midrst_perr", 32'(instr_parity_err), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    repeat (3) tick();
    chk("post_rst_idle", 32'(instr_valid), 32'd0);
    instr_ready = 1'b1;
    expect_run(6'd10, 4);
    redirect_to(6'd10);
    drain(cyc);
    chk("post_rst_cycles", 32'(cyc), 32'd5);
    finish_stream();

    // Halt wins over a same-cycle redirect
    halt = 1'b1; redirect_valid = 1'b1; redirect_pc = 6'd7;
    tick();
    halt = 1'b0; redirect_valid = 1'b0;
    chk("prio_busy", 32'(busy), 32'd0);
    tick();
    chk("prio_valid", 32'(instr_valid), 32'd0);
    chk("prio_busy2", 32'(busy), 32'd0);

`ifdef IMEM_PARITY_EN
    dut.r_mem[5][DW] = ~dut.r_mem[5][DW];
    bad_en = 1'b1;
`endif
    instr_ready = 1'b1;
    expect_run(6'd3, 4);
    redirect_to(6'd3);
    drain(cyc);
    chk("parity_cycles", 32'(cyc), 32'd5);
    finish_stream();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
